// File: rtl/noise_injector.sv
// Fault/noise injector: corrupts masked bits of a bus with force-1, force-0 or flip faults,
// gated by a periodic burst window and/or an LFSR-random condition; counts injected cycles.
module noise_injector #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PERIOD_W = 8,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [1:0]          kind,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] burst,
  input  logic [7:0]          thresh,
  input  logic [WIDTH-1:0]    chan_mask,
  input  logic                cnt_clr,
  input  logic [WIDTH-1:0]    sig_in,
  output logic [WIDTH-1:0]    sig_out,
  output logic                inject,
  output logic [15:0]         inject_cnt
);

  typedef enum logic [1:0] {
    KIND_SET  = 2'b00,
    KIND_CLR  = 2'b01,
    KIND_FLIP = 2'b10,
    KIND_PASS = 2'b11
  } kind_e;

  logic [PERIOD_W-1:0] cnt;
  logic [15:0]         lfsr;
  logic                lfsr_fb;
  logic                per_hit;
  logic                rnd_hit;
  kind_e               kind_sel;

  assign kind_sel = kind_e'(kind);
  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign per_hit  = (cnt < burst);
  assign rnd_hit  = (lfsr[7:0] < thresh);
  assign inject   = en & ((mode[0] & per_hit) | (mode[1] & rnd_hit)) & (kind_sel != KIND_PASS);

  // NOTE: sig_out gets its pass-through value first so every path assigns it and no latch is inferred.
  always_comb begin
    sig_out = sig_in;
    if (inject) begin
      case (kind_sel)
        KIND_SET:  sig_out = sig_in | chan_mask;
        KIND_CLR:  sig_out = sig_in & ~chan_mask;
        KIND_FLIP: sig_out = sig_in ^ chan_mask;
        default:   sig_out = sig_in;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // cnt is held at 0 while idle, so the first enabled cycle always opens a burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      lfsr       <= SEED;
      inject_cnt <= '0;
    end else begin
      if (!en || (cnt >= period)) cnt <= '0;
      else                        cnt <= cnt + PERIOD_W'(1);

      if (en) lfsr <= {lfsr[14:0], lfsr_fb};

      if (cnt_clr)                              inject_cnt <= '0;
      else if (inject && inject_cnt != 16'hFFFF) inject_cnt <= inject_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_noise_injector.sv
// Scoreboard bench for noise_injector: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_noise_injector;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst, en, cnt_clr;
  logic [1:0] mode, kind;
  logic [7:0] period, burst, thresh, chan_mask, sig_in, sig_out;
  logic       inject;
  logic [15:0] inject_cnt;

  noise_injector #(.WIDTH(8), .PERIOD_W(8), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .kind(kind),
    .period(period), .burst(burst), .thresh(thresh), .chan_mask(chan_mask),
    .cnt_clr(cnt_clr), .sig_in(sig_in), .sig_out(sig_out),
    .inject(inject), .inject_cnt(inject_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  out;
    logic        inj;
    logic [15:0] icnt;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] e_cnt = '0;
  logic [15:0] m_lfsr = SEED;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, " sig_out"}, {8'h00, sig_out}, {8'h00, e.out});
      check({e.tag, " inject"}, {15'h0, inject}, {15'h0, e.inj});
      check({e.tag, " inject_cnt"}, inject_cnt, e.icnt);
    end
  end

  // One clock: queue this cycle's expectation, then advance the spec-level counter/LFSR model.
  task automatic drive_push(input logic [7:0] eo, input logic ei, input string tag,
                            input bit quiet = 1'b0);
    exp_t e;
    if (!quiet) begin
      e.out = eo; e.inj = ei; e.icnt = e_cnt; e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      m_lfsr = SEED;
      e_cnt  = '0;
    end else begin
      if (en) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      if (cnt_clr)                       e_cnt = '0;
      else if (ei && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
    end
    #1;
  endtask

  task automatic idle();
    en = 1'b0;
    drive_push(sig_in, 1'b0, "idle");
  endtask

  task automatic random_cycle(input string tag);
    logic hit;
    hit = (m_lfsr[7:0] < thresh);
    drive_push(hit ? (sig_in ^ chan_mask) : sig_in, hit, tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cnt_clr = 1'b0; mode = 2'b00; kind = 2'b00;
    period = 8'd0; burst = 8'd0; thresh = 8'd0; chan_mask = 8'h00; sig_in = 8'h5A;
    @(posedge clk); #1;

    // 1: reset state
    drive_push(8'h5A, 1'b0, "t1 reset");
    drive_push(8'h5A, 1'b0, "t1 reset");
    rst = 1'b0;

    // 2: one-cycle burst every 11 clocks
    mode = 2'b01; kind = 2'b00; period = 8'd10; burst = 8'd1; chan_mask = 8'hFF; sig_in = 8'h00;
    en = 1'b1;
    for (int i = 0; i < 33; i++)
      drive_push((i % 11 == 0) ? 8'hFF : 8'h00, (i % 11 == 0), "t2 periodic");
    idle();

    // 3: flip then force-0 with a 3-of-5 burst
    kind = 2'b10; period = 8'd4; burst = 8'd3; chan_mask = 8'h0F; sig_in = 8'hAA; en = 1'b1;
    for (int i = 0; i < 15; i++)
      drive_push((i % 5 < 3) ? 8'hA5 : 8'hAA, (i % 5 < 3), "t3 flip");
    kind = 2'b01; chan_mask = 8'hF0;
    for (int i = 0; i < 10; i++)
      drive_push((i % 5 < 3) ? 8'h0A : 8'hAA, (i % 5 < 3), "t3 force0");
    idle();

    // 4: random mode, thresh=0 never fires, thresh=128 tracks the reference LFSR
    mode = 2'b10; kind = 2'b10; chan_mask = 8'hFF; thresh = 8'd0; en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      sig_in = 8'(i);
      drive_push(sig_in, 1'b0, "t4 thresh0");
    end
    thresh = 8'd128;
    for (int i = 0; i < 1000; i++) begin
      sig_in = 8'(i * 7);
      random_cycle("t4 random");
    end
    sig_in = 8'h00;
    idle();

    // 5: period lowered below cnt mid-run, then en drop restarts cnt
    mode = 2'b01; kind = 2'b00; chan_mask = 8'hFF; period = 8'd20; burst = 8'd0; en = 1'b1;
    for (int i = 0; i < 15; i++) drive_push(8'h00, 1'b0, "t5 burst0");
    period = 8'd3; burst = 8'd1;
    drive_push(8'h00, 1'b0, "t5 cnt15");
    drive_push(8'hFF, 1'b1, "t5 wrap");
    for (int i = 0; i < 3; i++) drive_push(8'h00, 1'b0, "t5 run");
    drive_push(8'hFF, 1'b1, "t5 wrap2");
    idle();
    en = 1'b1;
    drive_push(8'hFF, 1'b1, "t5 restart");
    drive_push(8'h00, 1'b0, "t5 after");

    // 6: saturation, clear-vs-inject, reset mid-burst
    period = 8'd10; burst = 8'd255;
    while (e_cnt != 16'hFFFE) drive_push(8'hFF, 1'b1, "t6 preload", 1'b1);
    for (int i = 0; i < 4; i++) drive_push(8'hFF, 1'b1, "t6 saturate");
    cnt_clr = 1'b1;
    drive_push(8'hFF, 1'b1, "t6 clr");
    cnt_clr = 1'b0;
    drive_push(8'hFF, 1'b1, "t6 after clr");
    drive_push(8'hFF, 1'b1, "t6 count");
    idle();
    burst = 8'd3; en = 1'b1;
    for (int i = 0; i < 3; i++) drive_push(8'hFF, 1'b1, "t6 burst");
    drive_push(8'h00, 1'b0, "t6 gap");
    rst = 1'b1;
    drive_push(8'h00, 1'b0, "t6 rst");
    rst = 1'b0;
    drive_push(8'hFF, 1'b1, "t6 post rst");
    drive_push(8'hFF, 1'b1, "t6 post rst2");

    // LFSR restarts from SEED after reset
    mode = 2'b10; kind = 2'b10; thresh = 8'd128;
    for (int i = 0; i < 20; i++) begin
      sig_in = 8'(i * 13);
      random_cycle("t6 lfsr reseed");
    end

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
